// File: rtl/alu_issue.sv
// Instruction FIFO and issue register feeding the alu inp bus.
// Multiply/divide words are held for a configurable number of cycles; all others for one.
module alu_issue #(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [15:0]                in_instr,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [15:0]                inp,
    output logic                       issue_valid,
    output logic                       retire,
    output logic [$clog2(DEPTH):0]     count
);

    // state | meaning
    // IDLE  | nothing presented; inp = 0, issue_valid = 0
    // BUSY  | inp holds a live word; hold counts down to its final cycle

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [3:0]    hold;
    logic [15:0]   head;
    logic [3:0]    head_lat;
    logic          push;
    logic          pop;
    logic          hold_done;

    assign head      = mem[rptr];
    assign in_ready  = (count != CW'(DEPTH));
    assign hold_done = (state == IDLE) || (hold == 4'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = !flush && (count != '0) && hold_done;
    assign retire    = (state == BUSY) && (hold == 4'd0) && !flush;

    always_comb begin
        head_lat = 4'd0;
        if (head[15:14] == 2'b00) begin
            if (head[3:0] == 4'b0001)
                head_lat = 4'(MUL_LAT - 1);
            else if (head[3:0] == 4'b0010)
                head_lat = 4'(DIV_LAT - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            inp         <= 16'h0000;
            issue_valid <= 1'b0;
            hold        <= 4'd0;
        end else if (flush) begin
            state       <= IDLE;
            inp         <= 16'h0000;
            issue_valid <= 1'b0;
            hold        <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        inp         <= head;
                        hold        <= head_lat;
                        issue_valid <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (hold != 4'd0) begin
                        hold <= hold - 4'd1;
                    end else if (pop) begin
                        // back-to-back issue: no bubble between words
                        inp  <= head;
                        hold <= head_lat;
                    end else begin
                        inp         <= 16'h0000;
                        issue_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: issue timing, hold latencies, full FIFO, flush and reset.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] inp;
    logic        issue_valid;
    logic        retire;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    alu_issue #(.DEPTH(4), .MUL_LAT(3), .DIV_LAT(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_instr    (in_instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inp         (inp),
        .issue_valid (issue_valid),
        .retire      (retire),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_issue(input string tag, input logic [15:0] w, input logic iv,
                                input logic rt);
        chk({tag, "_inp"}, 32'(inp), 32'(w));
        chk({tag, "_iv"},  32'(issue_valid), 32'(iv));
        chk({tag, "_ret"}, 32'(retire), 32'(rt));
    endtask

    task automatic push_word(input logic [15:0] w);
        in_instr = w;
        in_valid = 1'b1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_instr = 16'h0000;
    endtask

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        #12;
        expect_issue("rst0", 16'h0000, 1'b0, 1'b0);
        chk("rst0_cnt", 32'(count), 32'd0);
        chk("rst0_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        step();

        // single add
        push_word(16'h081F);
        step();
        idle_in();
        chk("add_cnt1", 32'(count), 32'd1);
        chk("add_iv_n", 32'(issue_valid), 32'd0);
        step();
        expect_issue("add_n1", 16'h081F, 1'b1, 1'b1);
        chk("add_cnt0", 32'(count), 32'd0);
        step();
        expect_issue("add_n2", 16'h0000, 1'b0, 1'b0);

        // multiply held 3 cycles, then queued add with no gap
        push_word(16'h0811);
        step();
        push_word(16'h081E);
        step();
        idle_in();
        expect_issue("mul_c1", 16'h0811, 1'b1, 1'b0);
        chk("mul_cnt", 32'(count), 32'd1);
        step();
        expect_issue("mul_c2", 16'h0811, 1'b1, 1'b0);
        step();
        expect_issue("mul_c3", 16'h0811, 1'b1, 1'b1);
        step();
        expect_issue("mul_next", 16'h081E, 1'b1, 1'b1);
        step();
        expect_issue("mul_idle", 16'h0000, 1'b0, 1'b0);

        // back-to-back single-cycle words
        push_word(16'h081F);
        step();
        push_word(16'h081E);
        step();
        expect_issue("b2b_0", 16'h081F, 1'b1, 1'b1);
        push_word(16'h081D);
        step();
        expect_issue("b2b_1", 16'h081E, 1'b1, 1'b1);
        push_word(16'h081C);
        step();
        idle_in();
        expect_issue("b2b_2", 16'h081D, 1'b1, 1'b1);
        chk("b2b_cnt", 32'(count), 32'd1);
        step();
        expect_issue("b2b_3", 16'h081C, 1'b1, 1'b1);
        chk("b2b_cnt0", 32'(count), 32'd0);
        step();
        expect_issue("b2b_idle", 16'h0000, 1'b0, 1'b0);

        // full FIFO behind a divide
        push_word(16'h0812);
        step();
        idle_in();
        step();
        expect_issue("div_c1", 16'h0812, 1'b1, 1'b0);
        push_word(16'h1234);
        step();
        push_word(16'h2345);
        step();
        push_word(16'h3456);
        step();
        push_word(16'h4567);
        step();
        chk("full_cnt", 32'(count), 32'd4);
        chk("full_rdy", 32'(in_ready), 32'd0);
        expect_issue("div_c5", 16'h0812, 1'b1, 1'b1);
        push_word(16'h5678);
        step();
        idle_in();
        chk("full_cnt3", 32'(count), 32'd3);
        chk("full_rdy1", 32'(in_ready), 32'd1);
        expect_issue("drain_a", 16'h1234, 1'b1, 1'b1);
        step();
        expect_issue("drain_b", 16'h2345, 1'b1, 1'b1);
        step();
        expect_issue("drain_c", 16'h3456, 1'b1, 1'b1);
        step();
        expect_issue("drain_d", 16'h4567, 1'b1, 1'b1);
        chk("drain_cnt", 32'(count), 32'd0);
        step();
        expect_issue("drain_idle", 16'h0000, 1'b0, 1'b0);

        // flush in divide hold cycle 2 with 2 words queued; push in flush cycle dropped
        push_word(16'h0812);
        step();
        push_word(16'h1111);
        step();
        push_word(16'h2222);
        step();
        chk("fl_pre_cnt", 32'(count), 32'd2);
        expect_issue("fl_pre", 16'h0812, 1'b1, 1'b0);
        push_word(16'h3333);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        expect_issue("fl_post", 16'h0000, 1'b0, 1'b0);
        chk("fl_cnt", 32'(count), 32'd0);
        step();
        expect_issue("fl_stay", 16'h0000, 1'b0, 1'b0);
        chk("fl_cnt2", 32'(count), 32'd0);

        // flush on a final hold cycle suppresses retire
        push_word(16'h081F);
        step();
        idle_in();
        step();
        expect_issue("flr_pre", 16'h081F, 1'b1, 1'b1);
        flush = 1'b1;
        #1;
        chk("flr_ret", 32'(retire), 32'd0);
        step();
        flush = 1'b0;
        expect_issue("flr_post", 16'h0000, 1'b0, 1'b0);

        // asynchronous reset mid-multiply
        push_word(16'h0811);
        step();
        push_word(16'h081E);
        step();
        idle_in();
        step();
        expect_issue("rm_c2", 16'h0811, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        expect_issue("rm_rst", 16'h0000, 1'b0, 1'b0);
        chk("rm_cnt", 32'(count), 32'd0);
        chk("rm_rdy", 32'(in_ready), 32'd1);
        step();
        expect_issue("rm_hold", 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        push_word(16'h081D);
        step();
        idle_in();
        chk("rr_cnt", 32'(count), 32'd1);
        step();
        expect_issue("rr_issue", 16'h081D, 1'b1, 1'b1);
        step();
        expect_issue("rr_idle", 16'h0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
